// File: rtl/conv_kernel_loader.sv
// conv_kernel_loader
//
// Loads a convolution kernel from a coefficient stream into a shadow buffer and
// applies it atomically to the active kernel at the next frame start (the pixel
// at row 0, col 0) or when commit_now_i is asserted. The pixel stream is passed
// through with one cycle of latency, so the frame-start pixel leaves together
// with the newly applied kernel.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active low
//   coef_i          coefficient beat (FP_WIDTH_REG bits)
//   coef_valid_i    beat valid
//   coef_last_i     marks the final beat of a kernel
//   coef_ready_o    beat ready (low only while a loaded kernel waits for commit)
//   commit_now_i    commit a pending kernel without waiting for a frame start
//   window_i        upstream pixel window [H][W]
//   col_i, row_i    upstream pixel coordinates
//   valid_i         upstream pixel valid
//   window_o, col_o, row_o, valid_o   pixel stream delayed by one cycle
//   kernel_o        active kernel [H][W], aligned with window_o
//   pending_o       a fully loaded kernel is waiting for commit
//   load_done_o     one-cycle pulse in the cycle the new kernel appears
//   error_o         one-cycle pulse after a malformed coefficient sequence

module conv_kernel_loader #(
    parameter int unsigned EXP_WIDTH     = 5,
    parameter int unsigned FRAC_WIDTH    = 10,
    parameter int unsigned WINDOW_WIDTH  = 2,
    parameter int unsigned WINDOW_HEIGHT = 1,
    parameter logic [EXP_WIDTH+FRAC_WIDTH:0] RESET_COEF = 16'h3C00,
    localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic [FP_WIDTH_REG-1:0] coef_i,
    input  logic                    coef_valid_i,
    input  logic                    coef_last_i,
    output logic                    coef_ready_o,
    input  logic                    commit_now_i,

    input  logic [FP_WIDTH_REG-1:0] window_i [WINDOW_HEIGHT][WINDOW_WIDTH],
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,

    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,

    output logic [FP_WIDTH_REG-1:0] kernel_o [WINDOW_HEIGHT][WINDOW_WIDTH],
    output logic                    pending_o,
    output logic                    load_done_o,
    output logic                    error_o
);

    localparam int unsigned N     = WINDOW_WIDTH * WINDOW_HEIGHT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StPending
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;
    logic               done_q, done_d;
    logic               shadow_we;
    logic               commit;
    logic               accept;
    logic               frame_start;

    logic [FP_WIDTH_REG-1:0] shadow_q [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] kernel_q [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] window_q [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [15:0]             col_q, row_q;
    logic                    valid_q;

    assign coef_ready_o = (state_q != StPending);
    assign pending_o    = (state_q == StPending);
    assign accept       = coef_valid_i && coef_ready_o;
    assign frame_start  = valid_i && (row_i == 16'd0) && (col_i == 16'd0);

    // Next-state logic. IDLE accepts beat 0 exactly like LOAD does with the
    // counter at 0, so both share one branch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        error_d   = 1'b0;
        done_d    = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;

        case (state_q)
            StIdle, StLoad: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (coef_last_i) begin
                        cnt_d = '0;
                        if (cnt_q == LAST_IDX) begin
                            state_d = StPending;
                        end else begin
                            // Short kernel: drop it; shadow is fully
                            // rewritten by the next complete load.
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        // Kernel too long: flag once, swallow the rest.
                        error_d = 1'b1;
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = StLoad;
                    end
                end
            end
            StDrain: begin
                if (accept && coef_last_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StPending: begin
                if (frame_start || commit_now_i) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    // Shadow buffer: beat k lands at [k / W][k % W].
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
                for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
                    shadow_q[r][c] <= RESET_COEF;
                end
            end
        end else if (shadow_we) begin
            for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
                for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
                    if (cnt_q == CNT_W'(r * int'(WINDOW_WIDTH) + c)) begin
                        shadow_q[r][c] <= coef_i;
                    end
                end
            end
        end
    end

    // Active kernel changes only on commit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
                for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
                    kernel_q[r][c] <= RESET_COEF;
                end
            end
        end else if (commit) begin
            kernel_q <= shadow_q;
        end
    end

    // Pixel pass-through, one cycle, never stalls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 0; r < int'(WINDOW_HEIGHT); r++) begin
                for (int c = 0; c < int'(WINDOW_WIDTH); c++) begin
                    window_q[r][c] <= '0;
                end
            end
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            window_q <= window_i;
            col_q    <= col_i;
            row_q    <= row_i;
            valid_q  <= valid_i;
        end
    end

    assign window_o    = window_q;
    assign col_o       = col_q;
    assign row_o       = row_q;
    assign valid_o     = valid_q;
    assign kernel_o    = kernel_q;
    assign load_done_o = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_conv_kernel_loader.sv
module tb_conv_kernel_loader;

    localparam int W  = 2;
    localparam int H  = 1;
    localparam int N  = W * H;
    localparam int FW = 16;
    localparam logic [15:0] RST_K = 16'h3C00;

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] coef;
    logic          coef_valid;
    logic          coef_last;
    logic          coef_ready;
    logic          commit_now;
    logic [FW-1:0] win_in  [H][W];
    logic [15:0]   col_in, row_in;
    logic          valid_in;
    logic [FW-1:0] win_out [H][W];
    logic [15:0]   col_out, row_out;
    logic          valid_out;
    logic [FW-1:0] kernel  [H][W];
    logic          pending;
    logic          load_done;
    logic          error;

    conv_kernel_loader dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .coef_i       (coef),
        .coef_valid_i (coef_valid),
        .coef_last_i  (coef_last),
        .coef_ready_o (coef_ready),
        .commit_now_i (commit_now),
        .window_i     (win_in),
        .col_i        (col_in),
        .row_i        (row_in),
        .valid_i      (valid_in),
        .window_o     (win_out),
        .col_o        (col_out),
        .row_o        (row_out),
        .valid_o      (valid_out),
        .kernel_o     (kernel),
        .pending_o    (pending),
        .load_done_o  (load_done),
        .error_o      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int pix_cnt = 0;

    // Behavioural model: kernel as a flat list, beats collected in a queue.
    logic [15:0] m_kernel [N];
    logic [15:0] m_shadow [N];
    logic [15:0] m_beats [$];
    bit          m_pending;
    bit          m_drain;
    logic [15:0] e_win [H][W];
    logic [15:0] e_col, e_row;
    logic        e_valid, e_done, e_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_kernel[i] = RST_K;
            m_shadow[i] = RST_K;
        end
        m_beats.delete();
        m_pending = 0;
        m_drain   = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                e_win[r][c] = '0;
        e_col = '0; e_row = '0; e_valid = 0; e_done = 0; e_err = 0;
    endtask

    // Expected outputs after the coming clock edge, from the current inputs.
    task automatic model_step();
        e_win = win_in; e_col = col_in; e_row = row_in; e_valid = valid_in;
        e_done = 0; e_err = 0;
        if (m_pending) begin
            if ((valid_in && row_in == 0 && col_in == 0) || commit_now) begin
                for (int i = 0; i < N; i++) m_kernel[i] = m_shadow[i];
                e_done    = 1;
                m_pending = 0;
            end
        end else if (coef_valid) begin
            if (m_drain) begin
                if (coef_last) m_drain = 0;
            end else begin
                m_beats.push_back(coef);
                if (coef_last) begin
                    if (m_beats.size() == N) begin
                        for (int i = 0; i < N; i++) m_shadow[i] = m_beats[i];
                        m_pending = 1;
                    end else begin
                        e_err = 1;
                    end
                    m_beats.delete();
                end else if (m_beats.size() == N) begin
                    e_err = 1;
                    m_drain = 1;
                    m_beats.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                chk($sformatf("%s.kernel[%0d][%0d]", tag, r, c), 32'(kernel[r][c]),
                    32'(m_kernel[r*W+c]));
                chk($sformatf("%s.window[%0d][%0d]", tag, r, c), 32'(win_out[r][c]),
                    32'(e_win[r][c]));
            end
        chk({tag, ".col"},       32'(col_out),    32'(e_col));
        chk({tag, ".row"},       32'(row_out),    32'(e_row));
        chk({tag, ".valid"},     32'(valid_out),  32'(e_valid));
        chk({tag, ".pending"},   32'(pending),    32'(m_pending));
        chk({tag, ".ready"},     32'(coef_ready), 32'(!m_pending));
        chk({tag, ".load_done"}, 32'(load_done),  32'(e_done));
        chk({tag, ".error"},     32'(error),      32'(e_err));
        if (load_done === 1'b1) done_seen++;
        if (error === 1'b1) err_seen++;
    endtask

    task automatic step(input logic cv, input logic [15:0] cd, input logic cl, input logic cn,
                        input logic pv, input logic [15:0] r, input logic [15:0] c);
        coef_valid = cv; coef = cd; coef_last = cl; commit_now = cn;
        valid_in = pv; row_in = r; col_in = c;
        pix_cnt++;
        for (int j = 0; j < W; j++) win_in[0][j] = 16'(pix_cnt * 4 + j + 16'h100);
        model_step();
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 0, 16'd5, 16'd5);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        coef = '0; coef_valid = 0; coef_last = 0; commit_now = 0;
        valid_in = 0; row_in = '0; col_in = '0;
        for (int j = 0; j < W; j++) win_in[0][j] = '0;
        model_reset();
        #12;
        do_reset("reset");

        // Frame starts with no load: kernel stays at reset value.
        step(0, 0, 0, 0, 1, 16'd0, 16'd0);
        step(0, 0, 0, 0, 1, 16'd0, 16'd1);
        step(0, 0, 0, 0, 1, 16'd0, 16'd0);
        chk("pin_reset_k0", 32'(kernel[0][0]), 32'h3C00);
        chk("pin_reset_k1", 32'(kernel[0][1]), 32'h3C00);
        chk("pin_no_done", done_seen, 0);

        // Normal 2-beat load, committed by a frame start.
        step(1, 16'h4000, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h4200, 1, 0, 0, 16'd3, 16'd3);
        chk("pin_pending", 32'(pending), 32'h1);
        step(0, 0, 0, 0, 1, 16'd0, 16'd1);
        step(0, 0, 0, 0, 1, 16'd0, 16'd0);
        chk("pin_load_k0", 32'(kernel[0][0]), 32'h4000);
        chk("pin_load_k1", 32'(kernel[0][1]), 32'h4200);
        chk("pin_load_done", 32'(load_done), 32'h1);
        chk("pin_load_col", 32'(col_out), 32'h0);
        idle();
        chk("pin_done_pulse", 32'(load_done), 32'h0);

        // Short kernel: error, kernel unchanged.
        step(1, 16'h4400, 1, 0, 0, 16'd3, 16'd3);
        chk("pin_short_err", 32'(error), 32'h1);
        idle();
        step(0, 0, 0, 0, 1, 16'd0, 16'd0);
        chk("pin_short_k0", 32'(kernel[0][0]), 32'h4000);

        // Long kernel: error after beat 2, beat 3 drained, then a good load.
        step(1, 16'h4600, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h4800, 0, 0, 0, 16'd3, 16'd3);
        chk("pin_long_err", 32'(error), 32'h1);
        step(1, 16'h4A00, 1, 0, 1, 16'd0, 16'd0);
        step(0, 0, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h5000, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h5200, 1, 0, 0, 16'd3, 16'd3);
        idle();
        step(0, 0, 0, 1, 0, 16'd3, 16'd3);
        chk("pin_long_k0", 32'(kernel[0][0]), 32'h5000);
        chk("pin_long_k1", 32'(kernel[0][1]), 32'h5200);
        chk("pin_err_count", err_seen, 2);

        // Pending with coef_valid held high, then both commit sources together.
        done_seen = 0;
        step(1, 16'h5400, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h5600, 1, 0, 0, 16'd3, 16'd3);
        for (int i = 0; i < 3; i++) step(1, 16'h7777, 1, 0, 0, 16'd3, 16'd3);
        chk("pin_ready_low", 32'(coef_ready), 32'h0);
        step(1, 16'h7777, 1, 1, 1, 16'd0, 16'd0);
        for (int i = 0; i < 3; i++) idle();
        chk("pin_single_done", done_seen, 1);
        chk("pin_dual_k1", 32'(kernel[0][1]), 32'h5600);

        // Reset mid-LOAD.
        step(1, 16'h3000, 0, 0, 1, 16'd2, 16'd2);
        do_reset("rst_load");
        chk("pin_rst_load_k0", 32'(kernel[0][0]), 32'h3C00);
        step(1, 16'h3400, 0, 0, 0, 16'd3, 16'd3);
        step(1, 16'h3800, 1, 0, 0, 16'd3, 16'd3);
        // Reset mid-PENDING.
        do_reset("rst_pend");
        chk("pin_rst_pend", 32'(pending), 32'h0);
        step(0, 0, 0, 0, 1, 16'd0, 16'd0);
        idle();
        chk("pin_rst_pend_k0", 32'(kernel[0][0]), 32'h3C00);
        chk("pin_rst_pend_k1", 32'(kernel[0][1]), 32'h3C00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_kernel_loader.md
CONV_KERNEL_LOADER -- requirements
Module: conv_kernel_loader

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 5, exponent width of the FP format.
REQ-002 SHALL have parameter FRAC_WIDTH, default 10, fraction width; FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH.
REQ-003 SHALL have parameters WINDOW_WIDTH, default 2, and WINDOW_HEIGHT, default 1; N = WINDOW_WIDTH * WINDOW_HEIGHT.
REQ-004 SHALL have parameter RESET_COEF, default 16'h3C00 (fp16 1.0), the kernel value after reset.
REQ-005 SHALL have port clk_i  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports coef_i (input, FP_WIDTH_REG), coef_valid_i (input, 1), coef_last_i (input, 1) and coef_ready_o (output, 1), forming the coefficient write stream.
REQ-008 SHALL have port commit_now_i  input  1  forces commit of a pending kernel without waiting for a frame start.
REQ-009 SHALL have ports window_i [H][W] (input, FP_WIDTH_REG), col_i (input, 16), row_i (input, 16) and valid_i (input, 1), the upstream pixel stream.
REQ-010 SHALL have ports window_o, col_o, row_o and valid_o, the pixel stream delayed one cycle, with the same widths as the corresponding inputs.
REQ-011 SHALL have port kernel_o [H][W]  output  FP_WIDTH_REG  active kernel, aligned with window_o.
REQ-012 SHALL have ports pending_o (output, 1), load_done_o (output, 1-cycle pulse) and error_o (output, 1-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, LOAD, DRAIN and PENDING, with coef_ready_o = 1 in IDLE, LOAD and DRAIN and 0 in PENDING.
REQ-014 SHALL treat a beat as accepted when coef_valid_i && coef_ready_o, and ignore coef_i otherwise.
REQ-015 SHALL write accepted beat k (k = 0..N-1) to shadow[k / WINDOW_WIDTH][k % WINDOW_WIDTH], with k counted from 0 by a counter that resets to 0 on every entry into IDLE.
REQ-016 SHALL, in IDLE, write an accepted beat to shadow[0][0], then: last && N==1 -> PENDING; !last -> LOAD.
REQ-017 SHALL, in LOAD, transition as follows on an accepted beat: last && k==N-1 -> PENDING; last && k<N-1 -> error_o pulse, shadow discarded, IDLE; !last && k==N-1 -> error_o pulse, DRAIN.
REQ-018 SHALL, in DRAIN, discard all accepted beats until a beat with last, then go to IDLE without a further error pulse.
REQ-019 SHALL hold pending_o = 1 exactly while in PENDING.
REQ-020 SHALL define a commit event in PENDING as (valid_i && row_i==0 && col_i==0) || commit_now_i; both sources in the same cycle produce exactly one commit.
REQ-021 SHALL, on a commit event in cycle t, present shadow on kernel_o from cycle t+1, pulse load_done_o in cycle t+1, and return to IDLE.
REQ-022 SHALL register window_o, col_o, row_o and valid_o from their inputs every cycle (latency 1, no stall), so the frame-start pixel leaves on window_o together with the new kernel_o.
REQ-023 SHALL keep kernel_o constant except at a commit.
REQ-024 SHALL NOT modify kernel_o on an error, and SHALL NOT apply partially loaded shadow contents.
REQ-025 SHALL ignore a frame start while in IDLE, LOAD or DRAIN (no commit, kernel_o unchanged).

Reset
REQ-026 SHALL, while rst_i = 0, asynchronously force: state IDLE, counter 0, every kernel_o and shadow element = RESET_COEF, valid_o, pending_o, load_done_o and error_o = 0, window_o, col_o and row_o = 0, coef_ready_o = 1.
REQ-027 SHALL discard any load or pending kernel in progress when reset asserts mid-operation; after release, kernel_o = RESET_COEF until the next commit.

Verification
REQ-028 SHALL cover: reset, then frame start with no load -> kernel_o = {3C00, 3C00} throughout, load_done_o stays 0.
REQ-029 SHALL cover: load {4000, 4200} (last on 2nd beat), then pixel row=0,col=0 valid -> pending_o=1 until that beat; next cycle kernel_o={4000,4200}, valid_o=1, col_o=0, load_done_o=1 for one cycle.
REQ-030 SHALL cover: load 1 beat 4400 with last (N=2) -> error_o pulse one cycle after acceptance, state IDLE, kernel_o unchanged.
REQ-031 SHALL cover: 3 beats, last only on the 3rd -> error_o after the 2nd beat, 3rd beat drained, then a valid 2-beat load completes normally.
REQ-032 SHALL cover: pending kernel with commit_now_i and frame start in the same cycle -> single load_done_o pulse; coef_valid_i held high while pending -> coef_ready_o=0 and no beats accepted.
REQ-033 SHALL cover: rst_i driven low mid-LOAD and mid-PENDING -> outputs take reset values immediately; kernel_o = 3C00 after release.
